prio_burst_sched: RTL and testbench

//  Shares one downstream beat port among NUM_REQ requesters. Fixed priority
//  (index 0 highest) with burst lock-in and anti-starvation aging.

---
 rtl/prio_burst_sched.sv | 130 +++++++++++++
 tb/tb_prio_burst_sched.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/prio_burst_sched.sv
// Fixed-priority beat scheduler with burst lock-in and starvation aging.
// Grants are combinational; ownership holds until the owner's last beat is accepted.
module prio_burst_sched #(
  parameter  int NUM_REQ      = 4,
  parameter  int STARVE_LIMIT = 15,
  localparam int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W        = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] last_i,
  input  logic               ready_i,
  output logic               vld_o,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               locked_o,
  output logic               starve_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
  logic [CNT_W-1:0]   cnt_q [NUM_REQ];
  logic [NUM_REQ-1:0] starved;
  logic [IDX_W-1:0]   sel;
  logic               starve_sel;
  logic               beat;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // Arbitration: starved set first (lowest index), then plain fixed priority; BURST pins the owner.
  always_comb begin
    logic found_s;
    logic found_r;
    logic [IDX_W-1:0] sel_s;
    logic [IDX_W-1:0] sel_r;
    starved    = '0;
    found_s    = 1'b0;
    found_r    = 1'b0;
    sel_s      = '0;
    sel_r      = '0;
    sel        = '0;
    starve_sel = 1'b0;
    vld_o      = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      starved[i] = (STARVE_LIMIT > 0) && req_i[i] && (cnt_q[i] == LIMIT);
      if (!found_s && starved[i]) begin
        sel_s   = IDX_W'(i);
        found_s = 1'b1;
      end
      if (!found_r && req_i[i]) begin
        sel_r   = IDX_W'(i);
        found_r = 1'b1;
      end
    end
    if (state_q == BURST) begin
      sel   = lock_idx_q;
      vld_o = req_i[lock_idx_q];
    end else begin
      sel        = found_s ? sel_s : sel_r;
      starve_sel = found_s;
      vld_o      = |req_i;
    end
    if (flush_i) begin
      vld_o      = 1'b0;
      starve_sel = 1'b0;
    end
    gnt_o    = vld_o ? (NUM_REQ'(1) << sel) : '0;
    idx_o    = sel;
    starve_o = starve_sel;
    locked_o = (state_q == BURST);
    beat     = vld_o & ready_i;
  end

  // Next-state: lock on a non-final IDLE beat, release on the owner's final beat; flush wins.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    if (flush_i) begin
      state_d    = IDLE;
      lock_idx_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (beat && !last_i[sel]) begin
            state_d    = BURST;
            lock_idx_d = sel;
          end
        end
        BURST: begin
          if (beat && last_i[lock_idx_q]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state and lock owner registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Aging counters: clear when idle or served, age only on beats lost to someone else.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (flush_i || !req_i[i] || (gnt_o[i] && ready_i)) begin
          cnt_q[i] <= '0;
        end else if ((STARVE_LIMIT > 0) && beat && (sel != IDX_W'(i)) && (cnt_q[i] != LIMIT)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prio_burst_sched.sv
// Scoreboard bench for prio_burst_sched (NUM_REQ=4, STARVE_LIMIT=3).
module tb_prio_burst_sched;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       flush_i;
  logic [3:0] req_i;
  logic [3:0] last_i;
  logic       ready_i;
  logic       vld_o;
  logic [3:0] gnt_o;
  logic [1:0] idx_o;
  logic       locked_o;
  logic       starve_o;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       locked;
    logic       starve;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  prio_burst_sched #(.NUM_REQ(4), .STARVE_LIMIT(3)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush_i  (flush_i),
    .req_i    (req_i),
    .last_i   (last_i),
    .ready_i  (ready_i),
    .vld_o    (vld_o),
    .gnt_o    (gnt_o),
    .idx_o    (idx_o),
    .locked_o (locked_o),
    .starve_o (starve_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle (called at posedge+1); optionally queue the expected presented beat.
  task automatic step(input logic [3:0] req, input logic [3:0] last, input logic rdy,
                      input logic ev, input logic [3:0] g, input logic [1:0] ix,
                      input logic lk, input logic st);
    exp_t e;
    req_i   = req;
    last_i  = last;
    ready_i = rdy;
    flush_i = 1'b0;
    if (ev) begin
      e = '{gnt: g, idx: ix, locked: lk, starve: st};
      exp_q.push_back(e);
    end
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every presented beat must match the head of the scoreboard.
  always @(negedge clk_i) begin
    exp_t e;
    if (vld_o === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got gnt=%b idx=%0d with nothing expected", gnt_o, idx_o);
      end else begin
        e = exp_q.pop_front();
        if (gnt_o !== e.gnt || idx_o !== e.idx || locked_o !== e.locked || starve_o !== e.starve) begin
          n_fail++;
          $display("FAIL beat: got gnt=%b idx=%0d lock=%b starve=%b expected gnt=%b idx=%0d lock=%b starve=%b",
                   gnt_o, idx_o, locked_o, starve_o, e.gnt, e.idx, e.locked, e.starve);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    req_i   = '0;
    last_i  = '0;
    ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_vld", {7'd0, vld_o}, 8'd0);
    chk("rst_gnt", {4'd0, gnt_o}, 8'd0);
    chk("rst_idx", {6'd0, idx_o}, 8'd0);
    chk("rst_locked", {7'd0, locked_o}, 8'd0);
    chk("rst_starve", {7'd0, starve_o}, 8'd0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // T1: req1/req2 single beats; req2 ages 1,2,3 then wins as starved.
    repeat (3) step(4'b0110, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b0);
    step(4'b0110, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

    // T2: 3-beat burst by req3; req0 arrives at beat 2 and waits.
    step(4'b1000, 4'b0000, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0, 1'b0);
    step(4'b1001, 4'b0000, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(4'b1001, 4'b1000, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

    // T3: req0 single beats, req2 held; 4th cycle req2 promoted, then back to req0.
    repeat (3) step(4'b0101, 4'b0101, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
    step(4'b0101, 4'b0101, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1);
    step(4'b0101, 4'b0101, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

    // T4: ready low for 10 cycles must not age req1; it then needs 3 lost beats.
    repeat (10) step(4'b0011, 4'b0011, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
    repeat (3) step(4'b0011, 4'b0011, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
    step(4'b0011, 4'b0011, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

    // T5: flush during a burst owned by req2 with req0 waiting.
    step(4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b0);
    step(4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0);
    req_i   = 4'b0101;
    last_i  = 4'b0000;
    ready_i = 1'b1;
    flush_i = 1'b1;
    #2;
    chk("flush_vld", {7'd0, vld_o}, 8'd0);
    chk("flush_gnt", {4'd0, gnt_o}, 8'd0);
    chk("flush_starve", {7'd0, starve_o}, 8'd0);
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    #1;
    chk("post_flush_locked", {7'd0, locked_o}, 8'd0);
    step(4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

    // T6: async reset mid-burst; req2's pre-reset age must be discarded.
    step(4'b0010, 4'b0000, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b0);
    step(4'b0111, 4'b0000, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
    req_i   = 4'b0111;
    last_i  = 4'b0000;
    ready_i = 1'b1;
    exp_q.push_back('{gnt: 4'b0001, idx: 2'd0, locked: 1'b0, starve: 1'b0});
    rst_ni  = 1'b0;
    #1;
    chk("reset_locked", {7'd0, locked_o}, 8'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (3) step(4'b0101, 4'b0101, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
    step(4'b0101, 4'b0101, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

    repeat (2) @(posedge clk_i);
    chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
